mult_seq_ctrl: RTL

Sequencing controller for the 8-bit shift-and-add multiplier datapath built from the 8/16-bit shift registers. Accepts a start request, then drives the shift-register load/shift controls, the accumulator add enable and the serial fill bit for exactly WIDTH iterations. Presents the finished product with a valid/ready handshake. Sits between the requesting logic and the multiplier datapath; it holds no operand or product data itself.

---
 rtl/mult_seq_ctrl_if.sv | 28 ++
 rtl/mult_seq_ctrl.sv | 103 ++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_if.sv
// Control bundle between a multiply requester/shift-and-add datapath and its sequencer.
// Master side = requester plus datapath status; slave side = the sequencer.
interface mult_seq_ctrl_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             start_ack;
  logic             mult_lsb;
  logic             carry_in;
  logic             load;
  logic             shift_stop;
  logic             add_en;
  logic             fill_bit;
  logic [CNT_W-1:0] bit_idx;
  logic             busy;
  logic             result_valid;
  logic             result_ready;

  modport master (
    output start, mult_lsb, carry_in, result_ready,
    input  start_ack, load, shift_stop, add_en, fill_bit, bit_idx, busy, result_valid
  );

  modport slave (
    input  start, mult_lsb, carry_in, result_ready,
    output start_ack, load, shift_stop, add_en, fill_bit, bit_idx, busy, result_valid
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Shift-and-add multiply sequencer: LOAD, then WIDTH x (EVAL [+ADD] + SHIFT), then DONE.
// Latency ack->valid = 2 + 2*WIDTH + popcount(multiplier); DONE holds until result_ready.
module mult_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic            clk,
  input logic            rst_n,
  mult_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    EVAL  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_IDX = CNT_W'(WIDTH);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] idx_q, idx_nxt;
  logic             carry_q, carry_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx_q   <= idx_nxt;
      carry_q <= carry_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    idx_nxt          = idx_q;
    carry_nxt        = carry_q;
    bus.start_ack    = 1'b0;
    bus.load         = 1'b0;
    bus.shift_stop   = 1'b1;
    bus.add_en       = 1'b0;
    bus.fill_bit     = 1'b0;
    bus.busy         = 1'b0;
    bus.result_valid = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          bus.start_ack = 1'b1;
          state_nxt     = LOAD;
        end
      end
      LOAD: begin
        bus.load       = 1'b1;
        bus.shift_stop = 1'b0;
        bus.busy       = 1'b1;
        idx_nxt        = '0;
        carry_nxt      = 1'b0;
        state_nxt      = EVAL;
      end
      EVAL: begin
        bus.busy = 1'b1;
        if (bus.mult_lsb) begin
          state_nxt = ADD;
        end else begin
          carry_nxt = 1'b0;
          state_nxt = SHIFT;
        end
      end
      ADD: begin
        bus.busy   = 1'b1;
        bus.add_en = 1'b1;
        carry_nxt  = bus.carry_in;
        state_nxt  = SHIFT;
      end
      SHIFT: begin
        bus.busy       = 1'b1;
        bus.shift_stop = 1'b0;
        // Adder carry from this iteration becomes the accumulator's new MSB.
        bus.fill_bit   = carry_q;
        if (idx_q < FULL_IDX) begin
          idx_nxt = idx_q + CNT_W'(1);
        end
        state_nxt = (idx_q >= LAST_IDX) ? DONE : EVAL;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.bit_idx = idx_q;

endmodule
